// File: rtl/sqrt_iter_unit.sv
// Iterative integer square root by odd-number subtraction.
// Returns floor(sqrt(valor_i)) and the remainder on a start/busy/done handshake.
module sqrt_iter_unit #(
  parameter int  DATA_WIDTH = 16,
  localparam int ROOT_WIDTH = DATA_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] valor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ROOT_WIDTH-1:0] root_o,
  output logic [ROOT_WIDTH:0]   rem_o
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [ROOT_WIDTH-1:0] ROOT_STEP = ROOT_WIDTH'(1);
  localparam logic [ROOT_WIDTH:0]   ODD_STEP  = (ROOT_WIDTH + 1)'(2);
  localparam logic [ROOT_WIDTH:0]   ODD_INIT  = (ROOT_WIDTH + 1)'(1);

  state_t                  state, state_nxt;
  logic [ROOT_WIDTH-1:0]   root;
  logic [DATA_WIDTH-1:0]   rem;
  logic [ROOT_WIDTH:0]     odd;
  logic [DATA_WIDTH:0]     diff;
  logic                    neg;
  logic                    accept, advance, finish;

  // One extra bit on the difference so its MSB acts as the borrow/sign flag.
  function automatic logic [DATA_WIDTH:0] widen_sub(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [ROOT_WIDTH:0]   b);
    return {1'b0, a} - {{(DATA_WIDTH - ROOT_WIDTH){1'b0}}, b};
  endfunction

  assign diff = widen_sub(rem, odd);
  assign neg  = diff[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (!neg) begin
          advance = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A request arriving in the done cycle is taken immediately.
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = ITER;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == ITER);
  assign done_o = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      root   <= '0;
      rem    <= '0;
      odd    <= '0;
      root_o <= '0;
      rem_o  <= '0;
    end else begin
      if (accept) begin
        root <= '0;
        rem  <= valor_i;
        odd  <= ODD_INIT;
      end else if (advance) begin
        root <= root + ROOT_STEP;
        rem  <= diff[DATA_WIDTH-1:0];
        odd  <= odd + ODD_STEP;
      end
      // Final remainder is at most 2*root, so the low R+1 bits hold it exactly.
      if (finish) begin
        root_o <= root;
        rem_o  <= rem[ROOT_WIDTH:0];
      end
    end
  end

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Bench for sqrt_iter_unit: directed handshake cases at 16 bits and a
// randomized sweep at 16 and 8 bits against an arithmetic square-root model.
module tb_sqrt_iter_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       s16, s8;
  logic [15:0] v16;
  logic [7:0]  v8;
  logic        b16, d16, b8, d8;
  logic [7:0]  r16;
  logic [8:0]  m16;
  logic [3:0]  r8;
  logic [4:0]  m8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_iter_unit #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(s16), .valor_i(v16),
    .busy_o(b16), .done_o(d16), .root_o(r16), .rem_o(m16)
  );

  sqrt_iter_unit #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .valor_i(v8),
    .busy_o(b8), .done_o(d8), .root_o(r8), .rem_o(m8)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Issue one request and wait for done; lat counts rising edges from the accept edge.
  task automatic run(input bit sel, input longint v, output longint r, output longint m,
                     output int lat, output int busy_n);
    bit seen;
    @(negedge clk);
    if (sel) begin s8 = 1'b1; v8 = v[7:0]; end
    else     begin s16 = 1'b1; v16 = v[15:0]; end
    lat = 0; busy_n = 0; r = 0; m = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      s8 = 1'b0; s16 = 1'b0;
      if (sel ? b8 : b16) busy_n++;
      if (sel ? d8 : d16) begin
        r = sel ? longint'(r8) : longint'(r16);
        m = sel ? longint'(m8) : longint'(m16);
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", longint'(seen), 1);
  endtask

  task automatic check_op(input bit sel, input longint v);
    longint r, m, er;
    int lat, bn;
    run(sel, v, r, m, lat, bn);
    er = isqrt(v);
    chk(sel ? "root8" : "root16", r, er);
    chk(sel ? "rem8" : "rem16", m, v - er * er);
    chk(sel ? "lat8" : "lat16", lat, er + 2);
  endtask

  initial begin
    longint r, m;
    int lat, bn, k;
    bit seen;

    rst = 1'b1; s16 = 1'b0; s8 = 1'b0; v16 = '0; v8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", b16, 0);
    chk("rst_done", d16, 0);
    chk("rst_root", r16, 0);
    chk("rst_rem", m16, 0);
    rst = 1'b0;

    run(1'b0, 0, r, m, lat, bn);
    chk("zero_root", r, 0); chk("zero_rem", m, 0);
    chk("zero_lat", lat, 2); chk("zero_busy", bn, 1);

    run(1'b0, 50, r, m, lat, bn);
    chk("r50_root", r, 7); chk("r50_rem", m, 1); chk("r50_lat", lat, 9);

    run(1'b0, 1, r, m, lat, bn);
    chk("r1_root", r, 1); chk("r1_rem", m, 0); chk("r1_lat", lat, 3);

    run(1'b0, 65535, r, m, lat, bn);
    chk("max_root", r, 255); chk("max_rem", m, 510); chk("max_lat", lat, 257);

    run(1'b0, 65025, r, m, lat, bn);
    chk("sq255_root", r, 255); chk("sq255_rem", m, 0);

    // Start held high with a changed operand during iteration of 50.
    @(negedge clk);
    s16 = 1'b1; v16 = 16'd50;
    @(posedge clk);
    @(negedge clk);
    v16 = 16'd100;
    lat = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (d16) break;
    end
    chk("hold_lat", lat, 9); chk("hold_root", r16, 7); chk("hold_rem", m16, 1);
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    chk("b2b_done_single", d16, 0);
    chk("b2b_busy", b16, 1);
    chk("b2b_root_kept", r16, 7);
    lat = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (d16) break;
    end
    chk("b2b_lat", lat, 12); chk("b2b_root", r16, 10); chk("b2b_rem", m16, 0);

    // Reset in the middle of a long computation.
    @(negedge clk);
    s16 = 1'b1; v16 = 16'd40000;
    @(posedge clk);
    @(negedge clk);
    s16 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", b16, 0); chk("mid_rst_done", d16, 0);
    chk("mid_rst_root", r16, 0); chk("mid_rst_rem", m16, 0);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (d16 || b16) seen = 1'b1;
    end
    chk("mid_rst_no_done", longint'(seen), 0);

    run(1'b0, 144, r, m, lat, bn);
    chk("r144_root", r, 12); chk("r144_rem", m, 0); chk("r144_lat", lat, 14);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; s16 = 1'b1; v16 = 16'd9;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s16 = 1'b0;
    chk("rst_start_busy", b16, 0);
    @(negedge clk);
    chk("rst_start_done", d16, 0);

    check_op(1'b1, 0);
    check_op(1'b1, 255);
    for (int i = 0; i < 300; i++) check_op(1'b1, longint'($urandom_range(0, 255)));

    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        check_op(1'b0, longint'($urandom_range(0, 65535)));
      end else begin
        k = int'($urandom_range(1, 255));
        check_op(1'b0, longint'(k * k - int'($urandom_range(0, 1))));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
